// File: rtl/base64_serializer_if.sv
// Handshake and serial-output bundle between a base64 character source and the serializer.
// master: character source / bit sink side; slave: the serializer itself.
interface base64_serializer_if;
    logic [7:0] in_char;
    logic       in_valid;
    logic       in_ready;
    logic       err_clr;
    logic       bit_out;
    logic       bit_valid;
    logic       frame_end;
    logic       err;

    modport master (
        output in_char, in_valid, err_clr,
        input  in_ready, bit_out, bit_valid, frame_end, err
    );

    modport slave (
        input  in_char, in_valid, err_clr,
        output in_ready, bit_out, bit_valid, frame_end, err
    );
endinterface

// File: rtl/base64_serializer.sv
// Decodes base64 ASCII characters and shifts each 6-bit symbol out MSB first.
// Latency: d[5] on bit_out the cycle after acceptance, one bit per cycle after that.
// Backpressure: in_ready only in IDLE or while d[0] is driven; never in ERR or reset.
module base64_serializer #(
    parameter logic [7:0] PAD_CHAR = 8'h3D
) (
    input  logic                clk,
    input  logic                rst,
    base64_serializer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, ERR} state_t;
    typedef enum logic [1:0] {K_DATA, K_PAD, K_BAD} kind_t;

    state_t      state_q, state_d;
    logic [5:0]  sh_q, sh_d;
    logic [2:0]  idx_q, idx_d;
    logic        bit_out_q, bit_out_d;
    logic        bit_valid_q, bit_valid_d;
    logic        frame_end_q, frame_end_d;
    logic        err_q, err_d;

    logic        rdy;
    logic        accept;
    kind_t       kind;
    logic [5:0]  val;
    logic [7:0]  off;

    // Pad is checked first so an overridden PAD_CHAR wins over the alphabet.
    always_comb begin
        kind = K_BAD;
        off  = 8'h00;
        if (bus.in_char == PAD_CHAR) begin
            kind = K_PAD;
        end else if (bus.in_char >= 8'h41 && bus.in_char <= 8'h5A) begin
            kind = K_DATA;
            off  = bus.in_char - 8'h41;
        end else if (bus.in_char >= 8'h61 && bus.in_char <= 8'h7A) begin
            kind = K_DATA;
            off  = bus.in_char - 8'h47;
        end else if (bus.in_char >= 8'h30 && bus.in_char <= 8'h39) begin
            kind = K_DATA;
            off  = bus.in_char + 8'h04;
        end else if (bus.in_char == 8'h2B) begin
            kind = K_DATA;
            off  = 8'd62;
        end else if (bus.in_char == 8'h2F) begin
            kind = K_DATA;
            off  = 8'd63;
        end
        val = off[5:0];
    end

    assign rdy    = rst && (state_q == IDLE || (state_q == SHIFT && idx_q == 3'd0));
    assign accept = bus.in_valid && rdy;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        idx_d       = idx_q;
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        frame_end_d = 1'b0;
        err_d       = err_q;
        case (state_q)
            IDLE, SHIFT: begin
                if (state_q == SHIFT && idx_q != 3'd0) begin
                    idx_d       = idx_q - 3'd1;
                    bit_out_d   = sh_q[idx_d];
                    bit_valid_d = 1'b1;
                end else if (accept) begin
                    case (kind)
                        K_DATA: begin
                            sh_d        = val;
                            idx_d       = 3'd5;
                            bit_out_d   = val[5];
                            bit_valid_d = 1'b1;
                            state_d     = SHIFT;
                        end
                        K_PAD: begin
                            frame_end_d = 1'b1;
                            idx_d       = 3'd0;
                            state_d     = IDLE;
                        end
                        default: begin
                            err_d   = 1'b1;
                            idx_d   = 3'd0;
                            state_d = ERR;
                        end
                    endcase
                end else begin
                    idx_d   = 3'd0;
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (bus.err_clr) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sh_q        <= 6'd0;
            idx_q       <= 3'd0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            frame_end_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            idx_q       <= idx_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            frame_end_q <= frame_end_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.frame_end = frame_end_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_base64_serializer.sv
// Directed bench for base64_serializer: reset, symbol bits, back-to-back, pad, error, mid-shift reset.
module tb_base64_serializer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    base64_serializer_if bus();

    base64_serializer #(.PAD_CHAR(8'h3D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic [7:0] ch, input string tag);
        @(negedge clk);
        chk({tag, "_rdy"}, bus.in_ready, 1);
        bus.in_char  = ch;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic collect(input int n, input logic [11:0] exp, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_v%0d", tag, i), bus.bit_valid, 1);
            chk($sformatf("%s_b%0d", tag, i), bus.bit_out, exp[n-1-i]);
        end
    endtask

    logic [7:0]  tbl_ch  [4] = '{8'h2B, 8'h39, 8'h61, 8'h5A};
    logic [11:0] tbl_val [4] = '{12'd62, 12'd61, 12'd26, 12'd25};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_char  = 8'h41;
        bus.in_valid = 1'b1;
        bus.err_clr  = 1'b0;
        rst          = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_rdy", bus.in_ready, 0);
            chk("rst_bv", bus.bit_valid, 0);
            chk("rst_err", bus.err, 0);
            chk("rst_fe", bus.frame_end, 0);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1 chk("rst_rel_rdy", bus.in_ready, 1);
        @(negedge clk);
        chk("rst_rel_bv", bus.bit_valid, 0);

        // 'h' = 33
        offer(8'h68, "h");
        collect(6, 12'b100001, "h");
        @(negedge clk);
        chk("h_end_bv", bus.bit_valid, 0);
        chk("h_end_bo", bus.bit_out, 0);

        // 'Q' then '/' with in_valid held: 12 contiguous bits
        @(negedge clk);
        bus.in_char  = 8'h51;
        bus.in_valid = 1'b1;
        fork
            begin
                @(posedge clk);
                #1 bus.in_char = 8'h2F;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (bus.in_ready) break;
                end
                chk("b2b_rdy", bus.in_ready, 1);
                @(posedge clk);
                #1 bus.in_valid = 1'b0;
            end
            collect(12, 12'b010000111111, "b2b");
        join
        @(negedge clk);
        chk("b2b_end_bv", bus.bit_valid, 0);

        // err_clr has no effect outside ERR
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1 bus.err_clr = 1'b0;
        @(negedge clk);
        chk("clr_idle_err", bus.err, 0);
        chk("clr_idle_rdy", bus.in_ready, 1);

        offer(8'h3D, "pad");
        @(negedge clk);
        chk("pad_fe", bus.frame_end, 1);
        chk("pad_bv", bus.bit_valid, 0);
        @(negedge clk);
        chk("pad_fe_off", bus.frame_end, 0);
        chk("pad_bv2", bus.bit_valid, 0);

        // '*' is invalid; 'A' offered while in ERR must be ignored
        offer(8'h2A, "bad");
        bus.in_char  = 8'h41;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("err_err", bus.err, 1);
            chk("err_rdy", bus.in_ready, 0);
            chk("err_bv", bus.bit_valid, 0);
            chk("err_fe", bus.frame_end, 0);
        end
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b1;
        @(posedge clk);
        #1 bus.err_clr = 1'b0;
        @(negedge clk);
        chk("clr_err", bus.err, 0);
        chk("clr_rdy", bus.in_ready, 1);
        chk("clr_bv", bus.bit_valid, 0);
        offer(8'h41, "A");
        collect(6, 12'b000000, "A");
        @(negedge clk);
        chk("A_end_bv", bus.bit_valid, 0);

        for (int t = 0; t < 4; t++) begin
            offer(tbl_ch[t], $sformatf("tbl%0d", t));
            collect(6, tbl_val[t], $sformatf("tbl%0d", t));
        end
        @(negedge clk);
        chk("tbl_end_bv", bus.bit_valid, 0);

        // 'z' = 51, reset after three bits
        offer(8'h7A, "z");
        collect(3, 12'b110, "z");
        rst = 1'b0;
        #1;
        chk("z_rst_bv", bus.bit_valid, 0);
        chk("z_rst_bo", bus.bit_out, 0);
        chk("z_rst_rdy", bus.in_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("z_post_bv", bus.bit_valid, 0);
            chk("z_post_rdy", bus.in_ready, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
